// File: rtl/aemb2_bdpsram_if.sv
// Bus bundle for the dual-port SRAM: port A, port X, and the status outputs.
// The master drives addresses, data and enables. The slave (the RAM) drives read data and status.
interface aemb2_bdpsram_if #(
  parameter int AW = 5,
  parameter int DW = 32
);
  localparam int BL = DW / 8;

  logic [AW-1:0] adr_i;
  logic [DW-1:0] dat_i;
  logic [BL-1:0] sel_i;
  logic          wre_i;
  logic          ena_i;
  logic [DW-1:0] dat_o;

  logic [AW-1:0] xadr_i;
  logic [DW-1:0] xdat_i;
  logic [BL-1:0] xsel_i;
  logic          xwre_i;
  logic          xena_i;
  logic [DW-1:0] xdat_o;

  logic          rdy_o;
  logic          col_o;

  modport master (
    output adr_i, dat_i, sel_i, wre_i, ena_i,
    output xadr_i, xdat_i, xsel_i, xwre_i, xena_i,
    input  dat_o, xdat_o, rdy_o, col_o
  );

  modport slave (
    input  adr_i, dat_i, sel_i, wre_i, ena_i,
    input  xadr_i, xdat_i, xsel_i, xwre_i, xena_i,
    output dat_o, xdat_o, rdy_o, col_o
  );
endinterface

// File: rtl/aemb2_bdpsram.sv
// Dual-port distributed SRAM with byte lanes, A-wins collision resolution and a post-reset zeroing sweep.
// Read addresses are registered and array reads are combinational.
module aemb2_bdpsram #(
  parameter int AW  = 5,
  parameter int DW  = 32,
  parameter bit CLR = 1'b1
) (
  input  logic               clk_i,
  input  logic               rst_i,
  aemb2_bdpsram_if.slave     bus
);
  localparam int BL    = DW / 8;
  localparam int DEPTH = 2 ** AW;

  if ((DW % 8) != 0) begin : g_dw_check
    $error("aemb2_bdpsram: DW must be a multiple of 8");
  end

  typedef enum logic {ST_CLEAR, ST_DONE} state_t;

  state_t        r_state;
  logic [AW-1:0] r_cnt;
  logic          r_rdy;
  logic          r_col;
  logic [AW-1:0] r_adr;
  logic [AW-1:0] r_xadr;
  logic [DW-1:0] r_mem [DEPTH];

  logic w_awe;
  logic w_xwe;
  logic w_clr;
  logic w_col;

  // Ports are ignored until the array has been initialised.
  assign w_awe = r_rdy & bus.ena_i & bus.wre_i;
  assign w_xwe = r_rdy & bus.xena_i & bus.xwre_i;
  assign w_clr = (r_state == ST_CLEAR);
  assign w_col = w_awe & w_xwe & (bus.adr_i == bus.xadr_i) & (|(bus.sel_i & bus.xsel_i));

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state <= CLR ? ST_CLEAR : ST_DONE;
      r_cnt   <= '0;
      r_rdy   <= 1'b0;
      r_col   <= 1'b0;
      r_adr   <= '0;
      r_xadr  <= '0;
    end else begin
      case (r_state)
        ST_CLEAR: begin
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == {AW{1'b1}}) begin
            r_state <= ST_DONE;
            r_rdy   <= 1'b1;
          end
        end
        default: r_rdy <= 1'b1;
      endcase
      r_col <= w_col;
      if (r_rdy && bus.ena_i)  r_adr  <= bus.adr_i;
      if (r_rdy && bus.xena_i) r_xadr <= bus.xadr_i;
    end
  end

  // NOTE: the array has no reset term so it maps onto distributed RAM; zeroing is done by the sweep.
  always_ff @(posedge clk_i) begin
    if (w_clr) begin
      r_mem[r_cnt] <= '0;
    end else begin
      // NOTE: port A is assigned after port X, so on a shared lane the later non-blocking write (A) wins.
      for (int n = 0; n < BL; n++) begin
        if (w_xwe && bus.xsel_i[n]) r_mem[bus.xadr_i][8*n +: 8] <= bus.xdat_i[8*n +: 8];
        if (w_awe && bus.sel_i[n])  r_mem[bus.adr_i][8*n +: 8]  <= bus.dat_i[8*n +: 8];
      end
    end
  end

  assign bus.dat_o  = r_rdy ? r_mem[r_adr]  : '0;
  assign bus.xdat_o = r_rdy ? r_mem[r_xadr] : '0;
  assign bus.rdy_o  = r_rdy;
  assign bus.col_o  = r_col;
endmodule
